cpuc_sequencer: RTL

- Control stage directly upstream of the CPUC grid; drives the tristate enables that the grid leaves unconnected.
- Holds a small loadable program memory and a PC, steps a fetch/drive/commit FSM, and emits one-hot enables:
  - component→register bus source select;
  - register→operand bus selects;
  - per-register write enables.
- Consumes the grid's compare result to resolve conditional jumps.

---
 rtl/cpuc_sequencer_if.sv | 36 +++
 rtl/cpuc_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cpuc_sequencer_if.sv
// Handshake and enable bundle between the CPUC sequencer and its surroundings.
// The slave modport is the sequencer's view; the master drives program load, start and the compare bit.
interface cpuc_sequencer_if #(
    parameter int NUM_SRC    = 8,
    parameter int NUM_DST    = 4,
    parameter int IMEM_DEPTH = 16
);
    localparam int SW = $clog2(NUM_SRC);
    localparam int DW = $clog2(NUM_DST);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int IW = 2 + DW + SW + DW + DW + AW;

    logic               start;
    logic               imem_we;
    logic [AW-1:0]      imem_addr;
    logic [IW-1:0]      imem_wdata;
    logic               cond_in;
    logic [NUM_SRC-1:0] src_en;
    logic [NUM_DST-1:0] dst_we;
    logic [NUM_DST-1:0] opa_en;
    logic [NUM_DST-1:0] opb_en;
    logic [AW-1:0]      pc;
    logic               busy;
    logic               halted;
    logic               err;

    modport master (
        output start, imem_we, imem_addr, imem_wdata, cond_in,
        input  src_en, dst_we, opa_en, opb_en, pc, busy, halted, err
    );

    modport slave (
        input  start, imem_we, imem_addr, imem_wdata, cond_in,
        output src_en, dst_we, opa_en, opb_en, pc, busy, halted, err
    );
endinterface

// File: rtl/cpuc_sequencer.sv
// Fetch/drive/commit sequencer for the CPUC grid: small program RAM, PC, and
// registered one-hot tristate enables for the component and register buses.
module cpuc_sequencer #(
    parameter int NUM_SRC    = 8,
    parameter int NUM_DST    = 4,
    parameter int IMEM_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    cpuc_sequencer_if.slave     bus
);
    localparam int SW = $clog2(NUM_SRC);
    localparam int DW = $clog2(NUM_DST);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int IW = 2 + DW + SW + DW + DW + AW;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DRIVE  = 3'd2;
    localparam logic [2:0] S_COMMIT = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_JMP  = 2'b01;
    localparam logic [1:0] OP_JMPC = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    typedef struct packed {
        logic [1:0]    op;
        logic [DW-1:0] dst;
        logic [SW-1:0] src;
        logic [DW-1:0] opa;
        logic [DW-1:0] opb;
        logic [AW-1:0] tgt;
    } instr_t;

    logic [IW-1:0]      r_imem [IMEM_DEPTH];
    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [AW-1:0]      r_pc;
    logic [AW-1:0]      w_pc_nxt;
    logic [AW-1:0]      w_pc_inc;
    instr_t             r_ir;
    instr_t             w_ir_nxt;
    instr_t             w_fetch;
    logic               r_cond;
    logic               r_err;
    logic               w_err_nxt;
    logic               w_busy;
    logic               w_illegal;
    logic               w_active;
    logic [NUM_SRC-1:0] r_src_en;
    logic [NUM_SRC-1:0] w_src_en_nxt;
    logic [NUM_DST-1:0] r_dst_we;
    logic [NUM_DST-1:0] w_dst_we_nxt;
    logic [NUM_DST-1:0] r_opa_en;
    logic [NUM_DST-1:0] w_opa_en_nxt;
    logic [NUM_DST-1:0] r_opb_en;
    logic [NUM_DST-1:0] w_opb_en_nxt;

    assign w_busy   = (r_state == S_FETCH) || (r_state == S_DRIVE) || (r_state == S_COMMIT);
    assign w_fetch  = instr_t'(r_imem[r_pc]);
    assign w_pc_inc = r_pc + AW'(1);

    // NOTE: the program RAM has no reset so it maps onto plain memory and survives rst.
    always_ff @(posedge clk) begin
        if (bus.imem_we && !w_busy) begin
            r_imem[bus.imem_addr] <= bus.imem_wdata;
        end
    end

    // NOTE: every output of this block is given a default first, so no latches are inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (bus.start) begin
                    w_state_nxt = S_FETCH;
                    w_pc_nxt    = '0;
                end
            end
            S_FETCH: begin
                w_ir_nxt    = w_fetch;
                w_state_nxt = S_DRIVE;
            end
            S_DRIVE: w_state_nxt = S_COMMIT;
            S_COMMIT: begin
                w_state_nxt = S_FETCH;
                case (r_ir.op)
                    OP_JMP:  w_pc_nxt = r_ir.tgt;
                    OP_JMPC: w_pc_nxt = r_cond ? r_ir.tgt : w_pc_inc;
                    OP_HALT: w_state_nxt = S_HALT;
                    default: w_pc_nxt = w_pc_inc;
                endcase
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Enables are decoded from the next state so they leave the flops glitch-free.
    assign w_illegal = (w_ir_nxt.op == OP_MOV) && (int'(w_ir_nxt.src) >= NUM_SRC);
    assign w_active  = (w_state_nxt == S_DRIVE) || (w_state_nxt == S_COMMIT);
    assign w_err_nxt = r_err | ((r_state == S_FETCH) && w_illegal);

    always_comb begin
        w_src_en_nxt = '0;
        w_dst_we_nxt = '0;
        w_opa_en_nxt = '0;
        w_opb_en_nxt = '0;
        if (w_active && !w_illegal) begin
            if (w_ir_nxt.op == OP_MOV) begin
                w_src_en_nxt = NUM_SRC'(1) << w_ir_nxt.src;
                w_opa_en_nxt = NUM_DST'(1) << w_ir_nxt.opa;
                w_opb_en_nxt = NUM_DST'(1) << w_ir_nxt.opb;
                if (w_state_nxt == S_COMMIT) begin
                    w_dst_we_nxt = NUM_DST'(1) << w_ir_nxt.dst;
                end
            end else if ((w_ir_nxt.op == OP_JMPC) && (w_state_nxt == S_DRIVE)) begin
                w_opa_en_nxt = NUM_DST'(1) << w_ir_nxt.opa;
                w_opb_en_nxt = NUM_DST'(1) << w_ir_nxt.opb;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_ir     <= '0;
            r_cond   <= 1'b0;
            r_err    <= 1'b0;
            r_src_en <= '0;
            r_dst_we <= '0;
            r_opa_en <= '0;
            r_opb_en <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_ir     <= w_ir_nxt;
            r_err    <= w_err_nxt;
            r_src_en <= w_src_en_nxt;
            r_dst_we <= w_dst_we_nxt;
            r_opa_en <= w_opa_en_nxt;
            r_opb_en <= w_opb_en_nxt;
            if ((r_state == S_DRIVE) && (r_ir.op == OP_JMPC)) begin
                r_cond <= bus.cond_in;
            end
        end
    end

    assign bus.src_en = r_src_en;
    assign bus.dst_we = r_dst_we;
    assign bus.opa_en = r_opa_en;
    assign bus.opb_en = r_opb_en;
    assign bus.pc     = r_pc;
    assign bus.busy   = w_busy;
    assign bus.halted = (r_state == S_HALT);
    assign bus.err    = r_err;

    // Bus-contention and write-window invariants seen by the grid.
    a_src_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(r_src_en));
    a_dst_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(r_dst_we));
    a_opa_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(r_opa_en));
    a_opb_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(r_opb_en));
    a_we_commit:  assert property (@(posedge clk) disable iff (!rst) (|r_dst_we) |-> (r_state == S_COMMIT));
endmodule
